// File: rtl/multiplier_iterative.sv
// Iterative multiplier: retires stride_p multiplier bits per cycle into a 2*width_p accumulator.
// Define MULTIPLIER_ITERATIVE_SIGNED_EN to honour signed_i (two's complement operation).
//
// state | meaning
// IDLE  | ready_o=1, waiting for v_i
// BUSY  | accumulating partial products, counter 0..N-1
// DONE  | v_o=1, c_o held until yumi_i
module multiplier_iterative #(
  parameter int width_p  = 32,
  parameter int stride_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_p-1:0]     a_i,
  input  logic [width_p-1:0]     b_i,
  input  logic                   signed_i,
  input  logic                   v_i,
  output logic                   ready_o,
  output logic [2*width_p-1:0]   c_o,
  output logic                   v_o,
  input  logic                   yumi_i
);

  localparam int iter_lp  = width_p / stride_p;
  localparam int cnt_w_lp = (iter_lp > 1) ? $clog2(iter_lp) : 1;
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(iter_lp - 1);

  generate
    if ((width_p % stride_p) != 0) begin : g_bad_stride
      $error("multiplier_iterative: stride_p must divide width_p evenly");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                  state_q;
  logic                    ready_q;
  logic                    v_q;
  logic [cnt_w_lp-1:0]     cnt_q;
  logic [2*width_p-1:0]    acc_q;
  logic [2*width_p-1:0]    mcand_q;
  logic [width_p-1:0]      mplier_q;

  logic [2*width_p-1:0]    mcand_init;
  logic [2*width_p-1:0]    acc_init;
  logic [2*width_p-1:0]    partial;

`ifdef MULTIPLIER_ITERATIVE_SIGNED_EN
  // Sign-extended multiplicand times the raw multiplier bits; a negative
  // multiplier is corrected by pre-loading -(a << width_p) into the accumulator.
  assign mcand_init = signed_i ? {{width_p{a_i[width_p-1]}}, a_i}
                               : {{width_p{1'b0}}, a_i};
  assign acc_init   = (signed_i && b_i[width_p-1])
                      ? ({(2*width_p){1'b0}} - {a_i, {width_p{1'b0}}})
                      : {(2*width_p){1'b0}};
`else
  logic unused_signed;
  assign unused_signed = signed_i;
  assign mcand_init    = {{width_p{1'b0}}, a_i};
  assign acc_init      = {(2*width_p){1'b0}};
`endif

  assign partial = mcand_q * {{(2*width_p-stride_p){1'b0}}, mplier_q[stride_p-1:0]};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      v_q      <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (v_i && ready_q) begin
            state_q  <= BUSY;
            ready_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= acc_init;
            mcand_q  <= mcand_init;
            mplier_q <= b_i;
          end
        end
        BUSY: begin
          acc_q    <= acc_q + partial;
          mcand_q  <= mcand_q << stride_p;
          mplier_q <= mplier_q >> stride_p;
          if (cnt_q == last_cnt_lp) begin
            state_q <= DONE;
            v_q     <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (yumi_i) begin
            state_q <= IDLE;
            v_q     <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          v_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_q & ~reset_i;
  assign v_o     = v_q;
  assign c_o     = acc_q;

`ifndef SYNTHESIS
  yumi_legal_a: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
    else $error("multiplier_iterative: yumi_i asserted while v_o=0");
`endif

endmodule
